pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_skid_slot.sv | 64 ++++++
 rtl/pipe_stage_reg.sv | 215 +++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-field widths per stage boundary,
// register index and word widths, and the skid-mode occupancy state type.
package pipe_pkg;

  localparam int WB_W      = 2;  // RegWrite, MemtoReg
  localparam int MEM_W     = 3;  // Branch, MemRead, MemWrite
  localparam int EX_W      = 4;  // RegDst, ALUSrc, ALUOp[1:0]
  localparam int REG_IDX_W = 5;
  localparam int WORD_W    = 32;

  // Pipeline boundary a register instance sits on
  typedef enum logic [1:0] {
    STG_IFID  = 2'd0,
    STG_IDEX  = 2'd1,
    STG_EXMEM = 2'd2,
    STG_MEMWB = 2'd3
  } stage_e;

  // Skid-mode occupancy, encoded as {main_v, skid_v}
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // Control width still carried at a given boundary; IF/ID has no decoded
  // control yet, so it keeps a single bit to leave the port legal.
  function automatic int ctrl_w_for(input stage_e stg);
    int w;
    case (stg)
      STG_IDEX:  w = WB_W + MEM_W + EX_W;
      STG_EXMEM: w = WB_W + MEM_W;
      STG_MEMWB: w = WB_W;
      default:   w = 1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+payload storage slot with load and clear. The control field is
// stored zeroed whenever the slot is empty, so a bubble never carries enables;
// the payload only captures on a valid load so X on an idle bus never enters.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = WB_W,
  parameter int PAY_W  = 2 * WORD_W + REG_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [PAY_W-1:0]  pay_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [PAY_W-1:0]  pay_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PAY_W-1:0]  pay_q, pay_d;

  // Next-state: clear wins over load; payload moves only with a valid entry
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pay_d   = pay_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = {CTRL_W{1'b0}};
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        ctrl_d = ctrl_i;
        pay_d  = pay_i;
      end else begin
        ctrl_d = {CTRL_W{1'b0}};
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot storage with asynchronous clear to an empty, all-zero entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{1'b0}};
      pay_q   <= {PAY_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pay_q   <= pay_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, flush-to-bubble and
// an optional two-entry skid mode whose in_ready comes straight from a flop.
// Output is always taken from the main slot; the skid slot only buffers the
// one entry accepted while the downstream stalls.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = WB_W,
  parameter int DATA_W = 2 * WORD_W,
  parameter int DEST_W = REG_IDX_W,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = DATA_W + DEST_W;

  logic [PAY_W-1:0]  in_pay;
  logic              main_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PAY_W-1:0]  main_pay;
  logic [1:0]        occ_q, occ_d;

  assign in_pay = {in_data, in_dest};

  generate
    if (SKID == 0) begin : g_single
      logic main_load;
      logic main_v_d;

      // Plain stage: accept whenever the held entry leaves or there is none
      assign in_ready  = out_ready | ~main_v;
      assign main_load = in_ready;

      // Occupancy follows the main slot's next valid bit
      always_comb begin
        main_v_d = main_v;
        if (flush) begin
          main_v_d = 1'b0;
        end else if (main_load) begin
          main_v_d = in_valid;
        end else begin
          main_v_d = main_v;
        end
        occ_d = {1'b0, main_v_d};
      end

      pipe_skid_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (flush),
        .valid_i (in_valid),
        .ctrl_i  (in_ctrl),
        .pay_i   (in_pay),
        .valid_o (main_v),
        .ctrl_o  (main_ctrl),
        .pay_o   (main_pay)
      );
    end else begin : g_skid
      skid_state_e       state_q, state_d;
      logic              in_ready_q, in_ready_d;
      logic              in_fire, out_fire;
      logic              main_load, main_clr, main_from_skid;
      logic              skid_load, skid_clr;
      logic              skid_v;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [PAY_W-1:0]  skid_pay;
      logic              main_vin;
      logic [CTRL_W-1:0] main_cin;
      logic [PAY_W-1:0]  main_pin;

      assign in_ready = in_ready_q;
      assign in_fire  = in_valid & in_ready_q;
      assign out_fire = main_v & out_ready;

      // Main slot refills either from the skid entry or from the input
      assign main_vin = main_from_skid ? skid_v    : in_valid;
      assign main_cin = main_from_skid ? skid_ctrl : in_ctrl;
      assign main_pin = main_from_skid ? skid_pay  : in_pay;

      // Occupancy FSM: slot control, next state and registered ready/count
      always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        case (state_q)
          SKID_EMPTY: begin
            if (in_fire) begin
              main_load = 1'b1;
              state_d   = SKID_ONE;
            end else begin
              state_d   = SKID_EMPTY;
            end
          end
          SKID_ONE: begin
            if (in_fire && out_fire) begin
              main_load = 1'b1;
              state_d   = SKID_ONE;
            end else if (in_fire) begin
              skid_load = 1'b1;
              state_d   = SKID_FULL;
            end else if (out_fire) begin
              main_clr  = 1'b1;
              state_d   = SKID_EMPTY;
            end else begin
              state_d   = SKID_ONE;
            end
          end
          SKID_FULL: begin
            if (out_fire) begin
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              skid_clr       = 1'b1;
              state_d        = SKID_ONE;
            end else begin
              state_d        = SKID_FULL;
            end
          end
          default: begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            state_d  = SKID_EMPTY;
          end
        endcase
        // Flush overrides every transfer decided above
        if (flush) begin
          main_load      = 1'b0;
          main_from_skid = 1'b0;
          skid_load      = 1'b0;
          main_clr       = 1'b1;
          skid_clr       = 1'b1;
          state_d        = SKID_EMPTY;
        end else begin
          state_d        = state_d;
        end
        in_ready_d = (state_d != SKID_FULL);
        case (state_d)
          SKID_ONE:  occ_d = 2'd1;
          SKID_FULL: occ_d = 2'd2;
          default:   occ_d = 2'd0;
        endcase
      end

      // FSM state and registered in_ready; ready stays low under reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q    <= SKID_EMPTY;
          in_ready_q <= 1'b0;
        end else begin
          state_q    <= state_d;
          in_ready_q <= in_ready_d;
        end
      end

      pipe_skid_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clr),
        .valid_i (main_vin),
        .ctrl_i  (main_cin),
        .pay_i   (main_pin),
        .valid_o (main_v),
        .ctrl_o  (main_ctrl),
        .pay_o   (main_pay)
      );

      pipe_skid_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .valid_i (in_valid),
        .ctrl_i  (in_ctrl),
        .pay_i   (in_pay),
        .valid_o (skid_v),
        .ctrl_o  (skid_ctrl),
        .pay_o   (skid_pay)
      );
    end
  endgenerate

  // Registered entry count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_pay[PAY_W-1:DEST_W];
  assign out_dest  = main_pay[DEST_W-1:0];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg: one instance per mode
// (SKID=0 as "a", SKID=1 as "b") sharing clock and reset.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [1:0]  a_in_ctrl, a_out_ctrl, a_occ;
  logic [63:0] a_in_data, a_out_data;
  logic [4:0]  a_in_dest, a_out_dest;
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [1:0]  b_in_ctrl, b_out_ctrl, b_occ;
  logic [63:0] b_in_data, b_out_data;
  logic [4:0]  b_in_dest, b_out_dest;

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(64), .DEST_W(5), .SKID(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .in_dest(a_in_dest), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .out_dest(a_out_dest), .occupancy(a_occ)
  );

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(64), .DEST_W(5), .SKID(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .in_dest(b_in_dest), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .out_dest(b_out_dest), .occupancy(b_occ)
  );

  typedef struct {
    logic        in_valid;
    logic [1:0]  in_ctrl;
    logic [63:0] in_data;
    logic [4:0]  in_dest;
    logic        flush;
    logic        out_ready;
    logic        exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_ctrl;
    logic [4:0]  exp_dest;
    logic [63:0] exp_data;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t a_tab[12];
  vec_t b_tab[14];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [63:0] d,
                              input logic [4:0] r, input logic fl, input logic ordy,
                              input logic erdy, input logic eov, input logic [1:0] ec,
                              input logic [4:0] er, input logic [63:0] ed, input logic [1:0] eo);
    vec_t t;
    t.in_valid = v;   t.in_ctrl = c;   t.in_data = d;   t.in_dest = r;
    t.flush = fl;     t.out_ready = ordy;
    t.exp_rdy = erdy; t.exp_ov = eov;  t.exp_ctrl = ec; t.exp_dest = er;
    t.exp_data = ed;  t.exp_occ = eo;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int sel, input vec_t v);
    if (sel == 0) begin
      a_in_valid = v.in_valid; a_in_ctrl = v.in_ctrl; a_in_data = v.in_data;
      a_in_dest = v.in_dest;   a_flush = v.flush;     a_out_ready = v.out_ready;
    end else begin
      b_in_valid = v.in_valid; b_in_ctrl = v.in_ctrl; b_in_data = v.in_data;
      b_in_dest = v.in_dest;   b_flush = v.flush;     b_out_ready = v.out_ready;
    end
  endtask

  task automatic run_row(input int sel, input string tag, input int idx, input vec_t v);
    @(negedge clk);
    drive(sel, v);
    #1;
    chk({tag, ".in_ready"}, idx, 64'(sel == 0 ? a_in_ready : b_in_ready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, idx, 64'(sel == 0 ? a_out_valid : b_out_valid), 64'(v.exp_ov));
    chk({tag, ".out_ctrl"},  idx, 64'(sel == 0 ? a_out_ctrl  : b_out_ctrl),  64'(v.exp_ctrl));
    chk({tag, ".occupancy"}, idx, 64'(sel == 0 ? a_occ       : b_occ),       64'(v.exp_occ));
    chk({tag, ".out_dest"},  idx, 64'(sel == 0 ? a_out_dest  : b_out_dest),  64'(v.exp_dest));
    chk({tag, ".out_data"},  idx, (sel == 0 ? a_out_data : b_out_data),      v.exp_data);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".a_out_valid"}, 0, 64'(a_out_valid), 64'd0);
    chk({tag, ".a_out_ctrl"},  0, 64'(a_out_ctrl),  64'd0);
    chk({tag, ".a_out_data"},  0, a_out_data,       64'd0);
    chk({tag, ".a_out_dest"},  0, 64'(a_out_dest),  64'd0);
    chk({tag, ".a_occ"},       0, 64'(a_occ),       64'd0);
    chk({tag, ".b_out_valid"}, 0, 64'(b_out_valid), 64'd0);
    chk({tag, ".b_out_ctrl"},  0, 64'(b_out_ctrl),  64'd0);
    chk({tag, ".b_out_data"},  0, b_out_data,       64'd0);
    chk({tag, ".b_out_dest"},  0, 64'(b_out_dest),  64'd0);
    chk({tag, ".b_occ"},       0, 64'(b_occ),       64'd0);
    chk({tag, ".b_in_ready"},  0, 64'(b_in_ready),  64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // SKID=0 vectors: v, ctrl, data, dest, flush, out_ready | rdy, ov, ctrl, dest, data, occ
    a_tab[0]  = mk(1'b1, 2'd3, 64'hDEADBEEF_00000004, 5'd9,  1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 5'd9,  64'hDEADBEEF_00000004, 2'd1);
    a_tab[1]  = mk(1'b1, 2'd1, 64'h1111,              5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 5'd9,  64'hDEADBEEF_00000004, 2'd1);
    a_tab[2]  = mk(1'b1, 2'd1, 64'h1111,              5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 5'd9,  64'hDEADBEEF_00000004, 2'd1);
    a_tab[3]  = mk(1'b1, 2'd1, 64'h1111,              5'd3,  1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 5'd3,  64'h1111, 2'd1);
    a_tab[4]  = mk(1'b0, 2'd3, 64'hFFFF,              5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd3,  64'h1111, 2'd0);
    a_tab[5]  = mk(1'b0, 2'd3, 64'hFFFF,              5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd3,  64'h1111, 2'd0);
    a_tab[6]  = mk(1'b0, 2'd3, 64'hFFFF,              5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd3,  64'h1111, 2'd0);
    a_tab[7]  = mk(1'b1, 2'd2, 64'hA5,                5'd17, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 5'd3,  64'h1111, 2'd0);
    a_tab[8]  = mk(1'b1, 2'd2, 64'hA5,                5'd17, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 5'd17, 64'hA5, 2'd1);
    a_tab[9]  = mk(1'b0, 2'd0, 64'h0,                 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd17, 64'hA5, 2'd0);
    a_tab[10] = mk(1'b1, 2'd1, 64'h77,                5'd31, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 5'd31, 64'h77, 2'd1);
    a_tab[11] = mk(1'b0, 2'bxx, {64{1'bx}},           5'bxxxxx, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd31, 64'h77, 2'd0);

    // SKID=1: 4-entry stream with 2-cycle stall, FULL+flush, flush with in_fire, refill to FULL
    b_tab[0]  = mk(1'b1, 2'd1, 64'h100, 5'd1,  1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 5'd1,  64'h100, 2'd1);
    b_tab[1]  = mk(1'b1, 2'd2, 64'h101, 5'd2,  1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 5'd2,  64'h101, 2'd1);
    b_tab[2]  = mk(1'b1, 2'd3, 64'h102, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 5'd2,  64'h101, 2'd2);
    b_tab[3]  = mk(1'b1, 2'd1, 64'h103, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd2,  64'h101, 2'd2);
    b_tab[4]  = mk(1'b1, 2'd1, 64'h103, 5'd4,  1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 5'd3,  64'h102, 2'd1);
    b_tab[5]  = mk(1'b1, 2'd1, 64'h103, 5'd4,  1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 5'd4,  64'h103, 2'd1);
    b_tab[6]  = mk(1'b0, 2'd0, 64'h0,   5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd4,  64'h103, 2'd0);
    b_tab[7]  = mk(1'b1, 2'd3, 64'h200, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 5'd7,  64'h200, 2'd1);
    b_tab[8]  = mk(1'b1, 2'd2, 64'h201, 5'd8,  1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 5'd7,  64'h200, 2'd2);
    b_tab[9]  = mk(1'b1, 2'd1, 64'h2FF, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd7,  64'h200, 2'd0);
    b_tab[10] = mk(1'b1, 2'd1, 64'h2FF, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 5'd7,  64'h200, 2'd0);
    b_tab[11] = mk(1'b0, 2'd0, 64'h0,   5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd7,  64'h200, 2'd0);
    b_tab[12] = mk(1'b1, 2'd2, 64'h300, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 5'd12, 64'h300, 2'd1);
    b_tab[13] = mk(1'b1, 2'd3, 64'h301, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 5'd12, 64'h300, 2'd2);

    reset = 1'b1;
    a_in_valid = 1'b0; a_in_ctrl = 2'd0; a_in_data = 64'd0; a_in_dest = 5'd0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ctrl = 2'd0; b_in_data = 64'd0; b_in_dest = 5'd0; b_flush = 1'b0; b_out_ready = 1'b0;

    #12;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset.a_in_ready", 0, 64'(a_in_ready), 64'd1);
    chk("post_reset.b_in_ready", 0, 64'(b_in_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_row(0, "skid0", i, a_tab[i]);
    @(negedge clk);
    a_in_valid = 1'b0; a_in_ctrl = 2'd0; a_in_data = 64'd0; a_in_dest = 5'd0;
    for (int i = 0; i < 14; i++) run_row(1, "skid1", i, b_tab[i]);

    // b is FULL here; assert reset between edges and expect an immediate clear
    #3;
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_reset.b_in_ready",  0, 64'(b_in_ready),  64'd1);
    chk("after_reset.b_occ",       0, 64'(b_occ),       64'd0);
    chk("after_reset.b_out_valid", 0, 64'(b_out_valid), 64'd0);
    chk("after_reset.a_in_ready",  0, 64'(a_in_ready),  64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
